// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, ROM address generation, IF/ID pipeline register
// and a fetch-fault state entered on misaligned or out-of-range fetch/redirect targets.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instrAddr,
    input  logic [31:0] instr,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        fetch_fault_o,
    output logic [31:0] fault_pc_o
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;

    function automatic logic in_range(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < ROM_DEPTH);
    endfunction

    assign instrAddr     = pc;
    assign fetch_fault_o = (state == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_instr_o <= '0;
            fault_pc_o <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    id_valid_o <= 1'b0;
                end
                RUN: begin
                    if (redirect_i) begin
                        id_valid_o <= 1'b0;
                        if (in_range(redirect_pc_i)) begin
                            pc <= redirect_pc_i;
                        end else begin
                            state      <= FAULT;
                            fault_pc_o <= redirect_pc_i;
                        end
                    end else if (flush_i) begin
                        id_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        // Out-of-range PC is only detected when it would actually issue
                        if (in_range(pc)) begin
                            id_valid_o <= 1'b1;
                            id_pc_o    <= pc;
                            id_instr_o <= instr;
                            pc         <= pc + 32'd4;
                        end else begin
                            state      <= FAULT;
                            fault_pc_o <= pc;
                            id_valid_o <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    id_valid_o <= 1'b0;
                    if (redirect_i) begin
                        if (in_range(redirect_pc_i)) begin
                            state <= RUN;
                            pc    <= redirect_pc_i;
                        end else begin
                            fault_pc_o <= redirect_pc_i;
                        end
                    end
                end
                default: begin
                    state      <= BOOT;
                    id_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then randomized
// control traffic checked every cycle against a behavioural fetch model.
module tb_if_stage;

    localparam int unsigned DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrAddr;
    logic [31:0] instr;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        fetch_fault_o;
    logic [31:0] fault_pc_o;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(32'h0000_0000), .ROM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instrAddr(instrAddr), .instr(instr),
        .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
        .id_instr_o(id_instr_o), .fetch_fault_o(fetch_fault_o), .fault_pc_o(fault_pc_o)
    );

    always #5 clk = ~clk;

    // ROM contents: word n holds the value n
    assign instr = instrAddr / 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the fetch unit as "just came out of reset / faulted / fetching"
    bit          m_fresh, m_faulted, m_valid;
    logic [31:0] m_pc, m_id_pc, m_id_instr, m_fault_pc;

    function automatic bit fetchable(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fresh <= 1; m_faulted <= 0; m_valid <= 0;
            m_pc <= 0; m_id_pc <= 0; m_id_instr <= 0; m_fault_pc <= 0;
        end else if (m_fresh) begin
            m_fresh <= 0;
        end else if (redirect_i) begin
            m_valid <= 0;
            if (fetchable(redirect_pc_i)) begin
                m_pc <= redirect_pc_i;
                m_faulted <= 0;
            end else begin
                m_faulted <= 1;
                m_fault_pc <= redirect_pc_i;
            end
        end else if (m_faulted || flush_i) begin
            m_valid <= 0;
        end else if (!stall_i) begin
            if (fetchable(m_pc)) begin
                m_valid <= 1; m_id_pc <= m_pc; m_id_instr <= m_pc / 4; m_pc <= m_pc + 4;
            end else begin
                m_faulted <= 1; m_fault_pc <= m_pc; m_valid <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("instrAddr", instrAddr, m_pc);
        chk("id_valid", 32'(id_valid_o), 32'(m_valid));
        chk("fetch_fault", 32'(fetch_fault_o), 32'(m_faulted));
        chk("fault_pc", fault_pc_o, m_fault_pc);
        if (m_valid) begin
            chk("id_pc", id_pc_o, m_id_pc);
            chk("id_instr", id_instr_o, m_id_instr);
        end
    end

    task automatic drive(input bit r, input logic [31:0] t, input bit s, input bit f);
        redirect_i = r; redirect_pc_i = t; stall_i = s; flush_i = f;
        @(posedge clk);
        #2;
    endtask

    task automatic id_is(input string name, input bit v, input logic [31:0] p, input logic [31:0] i);
        chk({name, ".valid"}, 32'(id_valid_o), 32'(v));
        if (v) begin
            chk({name, ".pc"}, id_pc_o, p);
            chk({name, ".instr"}, id_instr_o, i);
        end
    endtask

    logic [31:0] tgt;
    int unsigned sel;

    initial begin
        #1;
        chk("reset.addr", instrAddr, 32'h0);
        chk("reset.valid", 32'(id_valid_o), 32'h0);
        chk("reset.fault", 32'(fetch_fault_o), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        drive(0, 0, 0, 0); id_is("boot", 0, 0, 0);
        drive(0, 0, 0, 0); id_is("seq0", 1, 32'h0, 32'd0);
        drive(0, 0, 0, 0); id_is("seq1", 1, 32'h4, 32'd1);
        drive(0, 0, 0, 0); id_is("seq2", 1, 32'h8, 32'd2);
        drive(0, 0, 0, 0); id_is("seq3", 1, 32'hC, 32'd3);

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            id_is("stall", 1, 32'hC, 32'd3);
            chk("stall.addr", instrAddr, 32'h10);
        end
        drive(0, 0, 0, 0); id_is("unstall", 1, 32'h10, 32'd4);

        drive(1, 32'h40, 1, 1); id_is("redir", 0, 0, 0);
        chk("redir.addr", instrAddr, 32'h40);
        drive(0, 0, 0, 0); id_is("redir.issue", 1, 32'h40, 32'd16);

        drive(1, 32'h42, 0, 0);
        chk("misalign.fault", 32'(fetch_fault_o), 32'h1);
        chk("misalign.fpc", fault_pc_o, 32'h42);
        drive(0, 0, 1, 1); drive(0, 0, 0, 0);
        chk("fault.hold", 32'(fetch_fault_o), 32'h1);
        chk("fault.valid", 32'(id_valid_o), 32'h0);
        drive(1, 32'h5000, 0, 0);
        chk("fault.refault", fault_pc_o, 32'h5000);
        drive(1, 32'h100, 0, 0);
        chk("recover.fault", 32'(fetch_fault_o), 32'h0);
        chk("recover.addr", instrAddr, 32'h100);

        drive(1, 32'h3FF0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
        id_is("top", 1, 32'h3FFC, 32'hFFF);
        drive(0, 0, 0, 0);
        chk("end.fault", 32'(fetch_fault_o), 32'h1);
        chk("end.fpc", fault_pc_o, 32'h4000);

        drive(1, 32'h200, 0, 0);
        drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        chk("pre_rst.valid", 32'(id_valid_o), 32'h1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(id_valid_o), 32'h0);
        chk("arst.pc", id_pc_o, 32'h0);
        chk("arst.instr", id_instr_o, 32'h0);
        chk("arst.fault", 32'(fetch_fault_o), 32'h0);
        chk("arst.fpc", fault_pc_o, 32'h0);
        chk("arst.addr", instrAddr, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0: tgt = $urandom_range(0, DEPTH - 1) * 4;
                1: tgt = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
                2: tgt = (DEPTH * 4) + ($urandom_range(0, 1000) * 4);
                default: tgt = (DEPTH * 4) - 4 * $urandom_range(1, 4);
            endcase
            if (sel < 2) begin
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
            end else begin
                drive(sel < 14, tgt, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            end
        end

        drive(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter ROM_DEPTH, default 4096, meaning the number of 32-bit words in the instruction ROM.
REQ-003 The block SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have instrAddr  output  32  byte address driven to the instruction ROM.
REQ-006 The block SHALL have instr  input  32  ROM read data, combinational from instrAddr in the same cycle.
REQ-007 The block SHALL have stall_i  input  1  decode-side hold request.
REQ-008 The block SHALL have flush_i  input  1  invalidate the IF/ID register.
REQ-009 The block SHALL have redirect_i  input  1  branch/jump/trap redirect request.
REQ-010 The block SHALL have redirect_pc_i  input  32  redirect target byte address.
REQ-011 The block SHALL have id_valid_o  output  1  IF/ID entry valid.
REQ-012 The block SHALL have id_pc_o  output  32  PC of the IF/ID instruction.
REQ-013 The block SHALL have id_instr_o  output  32  IF/ID instruction word.
REQ-014 The block SHALL have fetch_fault_o  output  1  fetch fault pending, held high while in FAULT.
REQ-015 The block SHALL have fault_pc_o  output  32  address that caused the fault.

Function
REQ-016 The block SHALL hold a 32-bit PC register and drive instrAddr = PC combinationally, with no added latency.
REQ-017 The block SHALL implement states BOOT, RUN, FAULT.
REQ-018 In BOOT, one rising edge SHALL move to RUN with PC unchanged and id_valid_o = 0 (one bubble cycle after reset).
REQ-019 In RUN, a PC is "in range" when PC[1:0] = 0 and PC>>2 < ROM_DEPTH.
REQ-020 In RUN, per-edge priority SHALL be redirect_i > flush_i > stall_i > normal advance.
REQ-021 Normal advance (in-range PC) SHALL set id_valid/id_pc/id_instr <= {1, PC, instr} and PC <= PC + 4, modulo 2^32; a new instruction issues every cycle.
REQ-022 stall_i without redirect/flush SHALL hold PC and all IF/ID registers unchanged.
REQ-023 flush_i without redirect SHALL clear id_valid_o and hold PC; id_pc/id_instr are don't-care.
REQ-024 redirect_i with an aligned, in-range redirect_pc_i SHALL set PC <= redirect_pc_i and clear id_valid_o, regardless of stall_i or flush_i.
REQ-025 redirect_i with a misaligned or out-of-range target SHALL enter FAULT with fault_pc_o <= redirect_pc_i, PC unchanged, id_valid_o <= 0.
REQ-026 Normal advance with an out-of-range PC SHALL enter FAULT with fault_pc_o <= PC and id_valid_o <= 0; stall_i delays this check.
REQ-027 In FAULT, fetch_fault_o = 1, id_valid_o = 0, and PC holds; flush_i and stall_i are ignored.
REQ-028 In FAULT, only redirect_i with a valid target SHALL exit to RUN with PC <= target; an invalid target SHALL stay in FAULT and update fault_pc_o.
REQ-029 In RUN or BOOT, fetch_fault_o SHALL be 0.

Reset
REQ-030 rst high SHALL immediately (asynchronously) force state = BOOT, PC = RESET_PC, id_valid_o = 0, id_pc_o = 0, id_instr_o = 0, fetch_fault_o = 0, fault_pc_o = 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight IF/ID entry and pending fault.
REQ-032 The block SHALL resume per REQ-018 on the first rising edge after rst deasserts.

Verification
REQ-033 Reset release, ROM word n = n: edge 1 gives id_valid = 0; edges 2-4 give (pc, instr) = (0,0), (4,1), (8,2).
REQ-034 stall_i high for 3 cycles at PC = 0x10: IF/ID holds {1, 0xC, 3} and instrAddr stays 0x10; next advance gives {1, 0x10, 4}.
REQ-035 redirect_i with target 0x40 while stall_i = 1 and flush_i = 1: next edge gives id_valid = 0 and instrAddr = 0x40; the following edge gives {1, 0x40, 16}.
REQ-036 redirect_i with target 0x42: fetch_fault_o = 1 and fault_pc_o = 0x42 after the edge; a later redirect to 0x100 returns to RUN with instrAddr = 0x100.
REQ-037 Sequential run to PC = 0x3FFC with ROM_DEPTH = 4096: 0x3FFC issues normally; the next edge faults with fault_pc_o = 0x4000.
REQ-038 rst asserted asynchronously mid-cycle with id_valid = 1: all outputs zero immediately and instrAddr = RESET_PC.
